// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Control FSM for a shared single-ALU, single-memory MIPS
//                datapath. Sequences each instruction over 3-5 states, drives
//                every mux select and write strobe, waits on memory ready,
//                counts retired instructions and halts on illegal encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             alu_zout,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic [2:0]       w_r_alu_op;
    logic             w_r_legal;
    logic             w_pc_write;
    logic             w_ir_write;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_reg_write;
    logic             w_retire;

    // R-type function decode: ALU operation and legality of func
    always_comb begin
        w_r_alu_op = 3'b010;
        w_r_legal  = 1'b1;
        case (func)
            6'b100000: w_r_alu_op = 3'b010;
            6'b100010: w_r_alu_op = 3'b110;
            6'b100100: w_r_alu_op = 3'b000;
            6'b100101: w_r_alu_op = 3'b001;
            6'b101010: w_r_alu_op = 3'b111;
            default:   w_r_legal  = 1'b0;
        endcase
    end

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and Moore output decode (FETCH/BRANCH strobes are Mealy)
    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_retire    = 1'b0;
        pc_src      = 2'b00;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = 2'b01;
                alu_op     = 3'b010;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here into the ALU-out register
                alu_src_b = 2'b11;
                alu_op    = 3'b010;
                case (opcode)
                    c_OP_RTYPE:       w_next = w_r_legal ? S_R_EXEC : S_HALT;
                    c_OP_LW, c_OP_SW: w_next = S_MEM_ADDR;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_ADDI:        w_next = S_I_EXEC;
                    default:          w_next = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b010;
                w_next    = (opcode == c_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                iord       = 1'b1;
                w_mem_read = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_WRITE: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = w_r_alu_op;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
                alu_op      = w_r_alu_op;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b110;
                pc_src     = 2'b01;
                w_pc_write = alu_zout;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b010;
                w_next    = S_I_WB;
            end
            S_I_WB: begin
                w_reg_write = 1'b1;
                alu_op      = 3'b010;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_HALT;
            end
        endcase
    end

    // Retired-instruction counter, bumped on the edge leaving a retiring state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    // Strobes are gated by reset so FETCH's Mealy strobes stay low in reset
    assign pc_write  = w_pc_write  & rst_n;
    assign ir_write  = w_ir_write  & rst_n;
    assign mem_read  = w_mem_read  & rst_n;
    assign mem_write = w_mem_write & rst_n;
    assign reg_write = w_reg_write & rst_n;
    assign state     = r_state;
    assign halted    = (r_state == S_HALT);
    assign retired   = r_retired;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences the shared single-ALU, single-memory MIPS datapath (register file, ALU, PC, unified memory) one instruction at a time, over 3-5 states per instruction.
- Decodes opcode/func and drives every datapath mux select and write strobe.
- Waits on a memory-ready handshake.
- Keeps a retired-instruction counter.
- Halts on an illegal instruction.

Parameters:
- CNT_W, 16, width of the retired-instruction counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- func  in  6  instruction[5:0] from the instruction register.
- alu_zout  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 00 ALU out, 01 ALU-out register (branch target), 10 jump target {pc[31:28], addr26, 00}.
- ir_write  out  1  load instruction register.
- iord  out  1  memory address source: 0 PC, 1 ALU-out register.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  write address: 0 rt, 1 rd.
- mem_to_reg  out  1  write data: 0 ALU-out register, 1 memory data register.
- alu_src_a  out  1  ALU input A: 0 PC, 1 register A.
- alu_src_b  out  2  ALU input B: 00 register B, 01 constant 4, 10 sign-extended imm16, 11 sign-extended imm16 shifted left 2.
- alu_op  out  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- state  out  4  current state encoding, for debug.
- halted  out  1  FSM is in HALT.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, HALT=12.
- Reset (rst_n low, asynchronous):
  - state=FETCH, retired=0, halted=0.
  - All strobes (pc_write, ir_write, mem_read, mem_write, reg_write) forced to 0 while rst_n is low.
  - Reset mid-instruction abandons the instruction with no write.
- Outputs are Moore decodes of state, except pc_write in FETCH and BRANCH and ir_write in FETCH. Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=010.
  - ir_write=pc_write=mem_ready, pc_src=00.
  - Stays in FETCH while mem_ready=0; on mem_ready=1 goes to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=010 (branch target precomputed into ALU-out).
  - Next state by opcode:
    - 000000 goes to R_EXEC if func is one of 100000, 100010, 100100, 100101, 101010; otherwise HALT.
    - 100011 or 101011 go to MEM_ADDR.
    - 000100 goes to BRANCH.
    - 000010 goes to JUMP.
    - 001000 goes to I_EXEC.
    - Any other opcode goes to HALT.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010. Next state is MEM_READ if opcode=100011, else MEM_WRITE.
- MEM_READ: iord=1, mem_read=1. Held until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Retires, then FETCH.
- MEM_WRITE: iord=1, mem_write=1. Held until mem_ready=1, then retires and goes to FETCH.
- R_EXEC:
  - alu_src_a=1, alu_src_b=00.
  - alu_op from func: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_op held from R_EXEC. Retires, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01, pc_write=alu_zout. Retires, then FETCH.
- JUMP: pc_src=10, pc_write=1. Retires, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=010. Then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, alu_op=010. Retires, then FETCH.
- HALT:
  - halted=1, all strobes 0.
  - Absorbing; only rst_n leaves it.
  - retired is frozen.
- retired increments by 1 on the clock edge that leaves a retiring state. MEM_WRITE retires only on its mem_ready edge. Wraps from 2^CNT_W-1 to 0.
- Latency with mem_ready tied to 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each memory wait cycle adds 1 cycle.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- An unknown value on opcode or func in DECODE is treated as illegal and goes to HALT.

Test Plan:
- Reset release, mem_ready=1, IR=add (opcode 000000, func 100000):
  - States 0,1,6,7,0.
  - ir_write and pc_write high in cycle 0; reg_write=1 with reg_dst=1 in cycle 3.
  - retired=1.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ:
  - States 0,1,2,3,3,3,4,0.
  - mem_read and iord high throughout MEM_READ; mem_to_reg=1 in MEM_WB.
- beq (000100):
  - alu_zout=1 in BRANCH gives pc_write=1 with pc_src=01.
  - alu_zout=0 gives pc_write=0.
  - Both cases take 3 cycles and retired increments by 1.
- sw (101011) with mem_ready held 0 for 3 cycles in FETCH:
  - ir_write stays 0 until mem_ready rises.
  - mem_write=1 only in state 5; reg_write never asserts.
- Illegal opcode 111111, and separately R-type func 000000:
  - DECODE goes to HALT (12) and halted=1.
  - State is unchanged after 20 clocks.
  - Asserting rst_n low then high returns the FSM to FETCH with halted=0 and retired=0.
- CNT_W=2, four j (000010) instructions: retired counts 1,2,3,0. rst_n asserted mid-R_EXEC drives state to 0 immediately with no reg_write.
